// File: rtl/ntt_pkg.sv
// Shared constants, state encoding and index split for the NTT stage sequencer.
package ntt_pkg;

    localparam int         BEATS_PER_STAGE = 256;
    localparam int         NUM_STAGES      = 5;
    localparam logic [2:0] P_MAX           = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP,
        DONE
    } state_t;

    // {k, j}: k = cnt / 4^p, j = cnt mod 4^p
    function automatic logic [15:0] split_kj(
        input logic [7:0] cnt,
        input logic [2:0] p
    );
        logic [3:0] sh;
        logic [8:0] mask;
        logic [7:0] kk;
        logic [7:0] jj;
        sh   = {p, 1'b0};
        mask = (9'd1 << sh) - 9'd1;
        kk   = cnt >> sh;
        jj   = cnt & mask[7:0];
        return {kk, jj};
    endfunction

endpackage

// File: rtl/ntt_stage_sequencer.sv
// Walks the five radix-4 NTT stages, emitting (k, j, p) beats with a
// valid/ready handshake and an optional drain gap between stages.
module ntt_stage_sequencer
    import ntt_pkg::*;
#(
    parameter int STAGE_GAP = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       inv,
    input  logic       ready,
    output logic       valid,
    output logic [7:0] k,
    output logic [7:0] j,
    output logic [2:0] p,
    output logic       last_in_stage,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] GAP_LOAD =
        (STAGE_GAP > 0) ? 8'(STAGE_GAP - 1) : 8'd0;
    localparam logic [7:0] LAST_BEAT = 8'(BEATS_PER_STAGE - 1);

    state_t     r_state;
    logic [2:0] r_p;
    logic [7:0] r_cnt;
    logic [7:0] r_gap;
    logic       r_inv;

    state_t     w_state_nxt;
    logic [2:0] w_p_nxt;
    logic [7:0] w_cnt_nxt;
    logic [7:0] w_gap_nxt;
    logic       w_inv_nxt;

    logic       w_run;
    logic       w_xfer;
    logic       w_last;
    logic       w_final;
    logic [2:0] w_p_step;
    logic [15:0] w_kj;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_p     <= 3'd0;
            r_cnt   <= 8'd0;
            r_gap   <= 8'd0;
            r_inv   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_p     <= w_p_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gap   <= w_gap_nxt;
            r_inv   <= w_inv_nxt;
        end
    end

    always_comb begin
        w_run    = (r_state == RUN);
        w_xfer   = w_run && ready;
        w_last   = (r_cnt == LAST_BEAT);
        w_final  = r_inv ? (r_p == P_MAX) : (r_p == 3'd0);
        w_p_step = r_inv ? (r_p + 3'd1) : (r_p - 3'd1);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_p_nxt     = r_p;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap;
        w_inv_nxt   = r_inv;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_inv_nxt   = inv;
                    w_p_nxt     = inv ? 3'd0 : P_MAX;
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_xfer) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                    if (w_last) begin
                        if (w_final) begin
                            w_state_nxt = DONE;
                        end else begin
                            w_p_nxt = w_p_step;
                            if (STAGE_GAP == 0) begin
                                w_state_nxt = RUN;
                            end else begin
                                w_gap_nxt   = GAP_LOAD;
                                w_state_nxt = GAP;
                            end
                        end
                    end
                end
            end
            GAP: begin
                if (r_gap == 8'd0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_gap_nxt = r_gap - 8'd1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // p stays visible through GAP so the next stage number is known early
    always_comb begin
        w_kj          = split_kj(r_cnt, r_p);
        valid         = w_run;
        k             = w_run ? w_kj[15:8] : 8'd0;
        j             = w_run ? w_kj[7:0] : 8'd0;
        p             = (w_run || r_state == GAP) ? r_p : 3'd0;
        last_in_stage = w_run && w_last;
        busy          = (r_state != IDLE);
        done          = (r_state == DONE);
    end

endmodule

// File: doc/ntt_stage_sequencer.md
NTT_STAGE_SEQUENCER -- requirements
Module: ntt_stage_sequencer

Interface
REQ-001 SHALL have parameter STAGE_GAP, default 8, meaning idle cycles inserted between stages for butterfly pipeline drain (0 legal, max 255).
REQ-002 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a full transform.
REQ-005 SHALL have port inv  input  1  stage order select, sampled with start: 0 = p 4 down to 0, 1 = p 0 up to 4.
REQ-006 SHALL have port ready  input  1  downstream address stage accepts current beat.
REQ-007 SHALL have port valid  output  1  k/j/p hold a beat.
REQ-008 SHALL have port k  output  8  outer group index.
REQ-009 SHALL have port j  output  8  inner offset index.
REQ-010 SHALL have port p  output  3  radix-4 stage number, 0..4.
REQ-011 SHALL have port last_in_stage  output  1  current beat is beat 255 of its stage.
REQ-012 SHALL have port busy  output  1  transform in progress.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL implement states IDLE, RUN, GAP, DONE.
REQ-015 SHALL, in IDLE with start=1, latch inv, load p (4 if inv=0, else 0), clear beat counter cnt (8 bit), enter RUN next cycle.
REQ-016 SHALL ignore start in RUN, GAP, DONE.
REQ-017 SHALL drive valid=1 only in RUN; transfer occurs when valid and ready both 1.
REQ-018 SHALL derive j = cnt mod 4^p and k = cnt / 4^p (j = low 2p bits of cnt, k = cnt shifted right 2p); p=4 gives k=0, j=cnt; p=0 gives j=0, k=cnt.
REQ-019 SHALL hold k, j, p, last_in_stage stable while valid=1 and ready=0.
REQ-020 SHALL increment cnt by 1 on each transfer; 256 transfers per stage, cnt wraps 255 to 0 at stage end.
REQ-021 SHALL assert last_in_stage combinationally when valid=1 and cnt=255.
REQ-022 SHALL, on transfer of beat 255 of a non-final stage, step p (minus 1 if inv=0, plus 1 if inv=1) and enter GAP, or RUN directly when STAGE_GAP=0.
REQ-023 SHALL remain in GAP exactly STAGE_GAP cycles with valid=0, then enter RUN.
REQ-024 SHALL, on transfer of beat 255 of final stage (p=0 if inv=0, p=4 if inv=1), enter DONE; no gap after final stage.
REQ-025 SHALL assert done=1 for exactly the one DONE cycle, then return to IDLE.
REQ-026 SHALL assert busy=1 in RUN, GAP, DONE; 0 in IDLE.
REQ-027 SHALL drive k, j, p, last_in_stage to 0 whenever valid=0 outside the hold case, except p keeps next-stage value during GAP.
REQ-028 SHALL produce 1280 transfers per transform; with ready tied high, start at cycle 0 gives first valid at cycle 1, final transfer at cycle 1+1280+4*STAGE_GAP-1, done one cycle later.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, enter IDLE with valid, busy, done, last_in_stage, k, j, p, cnt all 0.
REQ-030 SHALL abort an in-progress transform on rst without asserting done; rst has priority over start in the same cycle.

Structure
REQ-031 SHALL take constants BEATS_PER_STAGE=256, NUM_STAGES=5, P_MAX=3'd4 and the state enum from shared package ntt_pkg.
REQ-032 SHALL be a single module with no sub-module; gap counter and beat counter are local registers.

Verification
REQ-033 inv=0, STAGE_GAP=8, ready=1, start at cycle 0 -> p sequence 4,3,2,1,0, valid first at cycle 1, final transfer at cycle 1312, done at cycle 1313, 1280 transfers.
REQ-034 p=1 stage, cnt=0..255 -> (k,j) = (0,0),(0,1),(0,2),(0,3),(1,0)...(63,3); last_in_stage only on (63,3).
REQ-035 inv=1, STAGE_GAP=0, ready=1 -> p sequence 0..4 with no valid gaps; done 1281 cycles after start.
REQ-036 random ready throttling (50%) -> outputs stable during stall, 1280 transfers, each (p,k,j) exactly once.
REQ-037 rst at cycle 600 mid-run -> next cycle IDLE, all outputs 0, no done; new start then completes normally.
REQ-038 start pulses during RUN, GAP, DONE -> ignored; single done per accepted start.
